// File: rtl/ram_bus_ctrl.sv
// Bus-slave front end for the on-chip byte-enabled synchronous RAM.
// Maps a valid/ready request channel onto RAM strobes and returns one buffered response per request.
module ram_bus_ctrl #(
  parameter int unsigned AW  = 32,
  parameter int unsigned RAW = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [AW-1:0]  req_addr_i,
  input  logic           req_we_i,
  input  logic [31:0]    req_wdata_i,
  input  logic [3:0]     req_sel_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [31:0]    rsp_rdata_o,
  output logic           rsp_err_o,
  output logic [RAW-1:0] ram_addr_o,
  output logic [31:0]    ram_data_o,
  output logic [3:0]     ram_sel_o,
  output logic           ram_we_o,
  input  logic [31:0]    ram_data_i
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FRESH = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] rdata_q, rdata_n;
  logic        err_q, err_n;

  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        err;

  assign misaligned = (req_addr_i[1:0] != 2'b00);

  // Upper address bits exist only when the bus is wider than the RAM window.
  generate
    if (AW > RAW + 2) begin : g_range_chk
      assign out_of_range = (req_addr_i[AW-1:RAW+2] != '0);
    end else begin : g_no_range_chk
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign err = misaligned | out_of_range;

  assign rsp_valid_o = (state_q != S_EMPTY);
  assign req_ready_o = ~rst & (~rsp_valid_o | rsp_ready_i);
  assign accept      = req_valid_i & req_ready_o;

  assign ram_addr_o = req_addr_i[RAW+1:2];
  assign ram_data_o = req_wdata_i;
  assign ram_sel_o  = req_sel_i;
  assign ram_we_o   = accept & req_we_i & ~err;

  always_comb begin
    state_n = state_q;
    rdata_n = rdata_q;
    err_n   = err_q;
    if (accept) begin
      // A new request always wins over the drain of the current response.
      if (req_we_i | err) begin
        state_n = S_HELD;
        rdata_n = '0;
        err_n   = err;
      end else begin
        state_n = S_FRESH;
        err_n   = 1'b0;
      end
    end else begin
      unique case (state_q)
        S_FRESH: begin
          if (rsp_ready_i) begin
            state_n = S_EMPTY;
          end else begin
            // Capture before the RAM read address moves on.
            state_n = S_HELD;
            rdata_n = ram_data_i;
          end
        end
        S_HELD: begin
          if (rsp_ready_i) state_n = S_EMPTY;
        end
        default: state_n = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      rdata_q <= rdata_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    unique case (state_q)
      S_FRESH: rsp_rdata_o = ram_data_i;
      S_HELD: begin
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Directed bench for ram_bus_ctrl with a behavioural byte-enabled RAM (registered read address).
module tb_ram_bus_ctrl;

  localparam int unsigned AW  = 32;
  localparam int unsigned RAW = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid_i;
  logic           req_ready_o;
  logic [AW-1:0]  req_addr_i;
  logic           req_we_i;
  logic [31:0]    req_wdata_i;
  logic [3:0]     req_sel_i;
  logic           rsp_valid_o;
  logic           rsp_ready_i;
  logic [31:0]    rsp_rdata_o;
  logic           rsp_err_o;
  logic [RAW-1:0] ram_addr_o;
  logic [31:0]    ram_data_o;
  logic [3:0]     ram_sel_o;
  logic           ram_we_o;
  logic [31:0]    ram_data_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_bus_ctrl #(.AW(AW), .RAW(RAW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_wdata_i (req_wdata_i),
    .req_sel_i   (req_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_o  (ram_data_o),
    .ram_sel_o   (ram_sel_o),
    .ram_we_o    (ram_we_o),
    .ram_data_i  (ram_data_i)
  );

  // RAM macro model: write at the edge, read address registered, read data combinational from it.
  logic [31:0]    mem [2**RAW];
  logic [RAW-1:0] raddr_q = '0;
  always @(posedge clk) begin
    if (ram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
    end
    raddr_q <= ram_addr_o;
  end
  assign ram_data_i = mem[raddr_q];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] sel);
    req_valid_i = v;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    req_sel_i   = sel;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    drive(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    tick();
    drive(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid_o); end
    checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h want 00000000", rsp_rdata_o); end
    checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %0b want 0", rsp_err_o); end
    checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %0b want 0", ram_we_o); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %0b want 0", req_ready_o); end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0b want 1", req_ready_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL idle_rsp_valid: got %0b want 0", rsp_valid_o); end
  endtask

  task automatic test_write_read();
    rsp_ready_i = 1'b1;
    drive(1'b1, 1'b1, 32'h0, 32'h12345678, 4'hF);
    checks++; if (ram_we_o !== 1'b1) begin errors++; $display("FAIL wr0_ram_we: got %0b want 1", ram_we_o); end
    tick();
    drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %0b want 1", req_ready_o); end
    checks++; if (ram_addr_o !== 12'h004) begin errors++; $display("FAIL wr_ram_addr: got %h want 004", ram_addr_o); end
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid: got %0b want 1", rsp_valid_o); end
    checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL wr_rsp_err: got %0b want 0", rsp_err_o); end
    checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL wr_rsp_rdata: got %h want 00000000", rsp_rdata_o); end
    checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL rd_ram_we: got %0b want 0", ram_we_o); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid: got %0b want 1", rsp_valid_o); end
    checks++; if (rsp_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rsp_rdata: got %h want deadbeef", rsp_rdata_o); end
    checks++; if (rsp_err_o !== 1'b0) begin errors++; $display("FAIL rd_rsp_err: got %0b want 0", rsp_err_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rd_drain: got %0b want 0", rsp_valid_o); end
  endtask

  task automatic test_byte_write();
    rsp_ready_i = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 32'h000000AA, 4'b0001);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++; if (rsp_rdata_o !== 32'hDEADBEAA) begin errors++; $display("FAIL byte_wr_rdata: got %h want deadbeaa", rsp_rdata_o); end
    tick();
  endtask

  task automatic test_sel_zero();
    rsp_ready_i = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 32'h11111111, 4'h0);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL sel0_rsp: got valid=%0b err=%0b want valid=1 err=0", rsp_valid_o, rsp_err_o); end
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++; if (rsp_rdata_o !== 32'hDEADBEAA) begin errors++; $display("FAIL sel0_rdata: got %h want deadbeaa", rsp_rdata_o); end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] addrs [5];
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = 32'h0; addrs[4] = 32'hC;
    rsp_ready_i = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, addrs[i], 32'h0, 4'hF);
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %0b want 0", i, req_ready_o); end
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hDEADBEAA) begin errors++; $display("FAIL stall_rdata[%0d]: got valid=%0b %h want valid=1 deadbeaa", i, rsp_valid_o, rsp_rdata_o); end
      tick();
    end
    rsp_ready_i = 1'b1;
    drive(1'b0, 1'b0, 32'h8, 32'h0, 4'h0);
    checks++; if (rsp_rdata_o !== 32'hDEADBEAA) begin errors++; $display("FAIL stall_release_rdata: got %h want deadbeaa", rsp_rdata_o); end
    tick();
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL stall_consumed: got %0b want 0", rsp_valid_o); end
  endtask

  task automatic test_errors();
    rsp_ready_i = 1'b1;
    drive(1'b1, 1'b0, 32'h11, 32'h0, 4'hF);
    checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL mis_ram_we: got %0b want 0", ram_we_o); end
    tick();
    drive(1'b1, 1'b1, 32'h1 << (RAW + 2), 32'hFFFFFFFF, 4'hF);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL mis_rsp: got valid=%0b err=%0b rdata=%h want 1 1 00000000", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL oor_ram_we: got %0b want 0", ram_we_o); end
    tick();
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL oor_rsp: got valid=%0b err=%0b rdata=%h want 1 1 00000000", rsp_valid_o, rsp_err_o, rsp_rdata_o); end
    tick();
    // Stall the follow-up read so a stale error flag would surface in the held response.
    rsp_ready_i = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checks++; if (rsp_rdata_o !== 32'h12345678 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL oor_unchanged: got %h err=%0b want 12345678 err=0", rsp_rdata_o, rsp_err_o); end
    rsp_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready_i = 1'b0;
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    tick();
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL mid_fresh_valid: got %0b want 1", rsp_valid_o); end
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    drive(1'b1, 1'b1, 32'h10, 32'h55555555, 4'hF);
    checks++; if (ram_we_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ram_we: got %0b want 0", ram_we_o); end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", rsp_valid_o); end
    drive(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    checks++; if (rsp_rdata_o !== 32'hDEADBEAA) begin errors++; $display("FAIL mid_rst_no_write: got %h want deadbeaa", rsp_rdata_o); end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    test_reset();
    test_write_read();
    test_byte_write();
    test_sel_zero();
    test_stall();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
